// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin two-requester arbiter:
// the FSM state encoding, the default sizes and a small arbitration helper.
package mux_arb_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int BURST_DEF = 4;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_A = 2'd1,
        ST_SERVE_B = 2'd2
    } arb_state_e;

    // Winner out of IDLE when both requesters are valid: whoever was not served last.
    function automatic arb_state_e pick_from_idle(
        input logic a_valid,
        input logic b_valid,
        input logic last_b
    );
        arb_state_e nxt;
        nxt = ST_IDLE;
        if (a_valid && b_valid) begin
            nxt = last_b ? ST_SERVE_A : ST_SERVE_B;
        end else if (a_valid) begin
            nxt = ST_SERVE_A;
        end else if (b_valid) begin
            nxt = ST_SERVE_B;
        end else begin
            nxt = ST_IDLE;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// Single-bit 2:1 multiplexer; the arbiter replicates it once per data bit.
module mux_rr_arbiter_mux (
    input  logic i_a,
    input  logic i_b,
    input  logic i_sel,
    output logic o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter with a per-grant burst limit and a single
// registered output word (valid/ready on every side).
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       state_o
);

    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_last_b;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_sel;

    logic             w_grant_b;
    logic             w_out_free;
    logic             w_a_fire;
    logic             w_b_fire;
    logic             w_fire;
    logic             w_burst_done;
    logic [WIDTH-1:0] w_mux_data;

    assign w_grant_b    = (r_state == ST_SERVE_B);
    assign w_out_free   = !r_out_valid || out_ready;
    assign w_a_fire     = (r_state == ST_SERVE_A) && a_valid && w_out_free;
    assign w_b_fire     = (r_state == ST_SERVE_B) && b_valid && w_out_free;
    assign w_fire       = w_a_fire || w_b_fire;
    assign w_cnt_inc    = r_burst_cnt + 8'd1;
    assign w_burst_done = w_fire && (w_cnt_inc == BURST_C);

    // Data path: one 1-bit mux per data bit, steered by the current grant.
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        mux_rr_arbiter_mux u_mux (
            .i_a   (a_data[g]),
            .i_b   (b_data[g]),
            .i_sel (w_grant_b),
            .o_y   (w_mux_data[g])
        );
    end

    // Next-state and burst-counter logic; any state change restarts the burst.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = pick_from_idle(a_valid, b_valid, r_last_b);
            end
            ST_SERVE_A: begin
                if (!a_valid) begin
                    w_state_nxt = b_valid ? ST_SERVE_B : ST_IDLE;
                end else if (w_burst_done) begin
                    if (b_valid) begin
                        w_state_nxt = ST_SERVE_B;
                    end else begin
                        w_state_nxt = ST_SERVE_A;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_a_fire) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_state_nxt = ST_SERVE_A;
                end
            end
            ST_SERVE_B: begin
                if (!b_valid) begin
                    w_state_nxt = a_valid ? ST_SERVE_A : ST_IDLE;
                end else if (w_burst_done) begin
                    if (a_valid) begin
                        w_state_nxt = ST_SERVE_A;
                    end else begin
                        w_state_nxt = ST_SERVE_B;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_b_fire) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_state_nxt = ST_SERVE_B;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // FSM state, burst counter and last-served flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_last_b    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_cnt_nxt;
            if (w_a_fire) begin
                r_last_b <= 1'b0;
            end else if (w_b_fire) begin
                r_last_b <= 1'b1;
            end
        end
    end

    // Output holding register: load on accept, drop when consumed, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_data;
            r_sel       <= w_grant_b;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign a_ready   = (r_state == ST_SERVE_A) && w_out_free;
    assign b_ready   = (r_state == ST_SERVE_B) && w_out_free;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel       = r_sel;
    assign state_o   = r_state;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized
// run scored against an in-order queue of accepted words.
module tb_mux_rr_arbiter;

    localparam int BURST = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic [7:0] a_data, b_data, out_data;
    logic       a_ready, b_ready, out_valid, sel;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_arbiter #(.WIDTH(8), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data = 8'h00; b_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0 || state_o !== 2'd0 ||
            a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state got v=%b d=%h s=%b st=%0d ar=%b br=%b exp all zero",
                     out_valid, out_data, sel, state_o, a_ready, b_ready);
        end
        a_valid = 1'b1; a_data = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77) begin
            n_errors++;
            $display("FAIL reset_preload got v=%b d=%h exp v=1 d=77", out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || state_o !== 2'd0 || a_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midstream got v=%b d=%h st=%0d ar=%b exp 0 00 0 0",
                     out_valid, out_data, state_o, a_ready);
        end
        a_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_release c%0d got v=%b ar=%b br=%b exp 0 0 0",
                         i, out_valid, a_ready, b_ready);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] words [3];
        int na, nout, first;
        logic fa;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        do_reset();
        out_ready = 1'b1; a_valid = 1'b1; a_data = words[0];
        na = 0; nout = 0; first = -1;
        for (int it = 0; it < 8; it++) begin
            @(negedge clk); fa = a_valid && a_ready;
            @(posedge clk); #1;
            if (out_valid) begin
                if (first < 0) first = it;
                n_checks++;
                if (nout >= 3 || out_data !== words[nout] || sel !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_word%0d got d=%h s=%b exp d=%h s=0",
                             nout, out_data, sel, (nout < 3) ? words[nout] : 8'hxx);
                end
                nout++;
            end
            if (fa) begin
                na++;
                if (na < 3) a_data = words[na]; else a_valid = 1'b0;
            end
        end
        n_checks++;
        if (first !== 1 || nout !== 3) begin
            n_errors++;
            $display("FAIL single_latency got first=%0d count=%0d exp first=1 count=3", first, nout);
        end
    endtask

    task automatic test_fairness();
        int na, nb, nout, idx, exp_sel, exp_k;
        logic fa, fb;
        logic [7:0] exp_d;
        do_reset();
        out_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
        na = 0; nb = 0; nout = 0;
        a_data = 8'h40; b_data = 8'h80;
        for (int it = 0; it < 20; it++) begin
            @(negedge clk); fa = a_valid && a_ready; fb = b_valid && b_ready;
            @(posedge clk); #1;
            if (out_valid) begin
                idx = nout;
                exp_sel = (idx / BURST) % 2;
                exp_k = (idx / (2 * BURST)) * BURST + idx % BURST;
                exp_d = (exp_sel == 0) ? 8'(8'h40 + exp_k) : 8'(8'h80 + exp_k);
                n_checks++;
                if (sel !== exp_sel[0] || out_data !== exp_d) begin
                    n_errors++;
                    $display("FAIL fair_out%0d got s=%b d=%h exp s=%0d d=%h", idx, sel, out_data, exp_sel, exp_d);
                end
                nout++;
            end else if (nout > 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fair_idle got out_valid=0 at iter %0d exp 1", it);
            end
            if (fa) begin na++; a_data = 8'(8'h40 + na); end
            if (fb) begin nb++; b_data = 8'(8'h80 + nb); end
        end
        n_checks++;
        if (nout !== 19) begin
            n_errors++;
            $display("FAIL fair_count got %0d exp 19", nout);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        a_valid = 1'b1; a_data = 8'hA5; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 a_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
                n_errors++;
                $display("FAIL bp_hold%0d got ar=%b v=%b d=%h exp 0 1 a5", i, a_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_release_ready got %b exp 1", a_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || sel !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_next got v=%b d=%h s=%b exp 1 5a 0", out_valid, out_data, sel);
        end
        a_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drain got v=%b exp 0", out_valid);
        end
    endtask

    task automatic test_early_drop();
        int na;
        logic fa;
        do_reset();
        out_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h01; b_data = 8'h02;
        na = 0;
        for (int it = 0; it < 10 && na < 2; it++) begin
            @(negedge clk); fa = a_valid && a_ready;
            @(posedge clk); #1;
            if (fa) na++;
        end
        a_valid = 1'b0;
        n_checks++;
        if (na !== 2) begin
            n_errors++;
            $display("FAIL drop_fires got %0d exp 2", na);
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 2'd2 || dut.r_burst_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL drop_state got st=%0d cnt=%0d exp st=2 cnt=0", state_o, dut.r_burst_cnt);
        end
        b_valid = 1'b0;
    endtask

    task automatic test_lone_burst();
        logic [7:0] words [10];
        int na, nout;
        logic fa;
        for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
        do_reset();
        out_ready = 1'b1; a_valid = 1'b1; a_data = words[0];
        na = 0; nout = 0;
        for (int it = 0; it < 30; it++) begin
            @(negedge clk); fa = a_valid && a_ready;
            @(posedge clk); #1;
            if (na < 10) begin
                n_checks++;
                if (state_o !== 2'd1) begin
                    n_errors++;
                    $display("FAIL lone_state it%0d got %0d exp 1", it, state_o);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (nout >= 10 || out_data !== words[nout] || sel !== 1'b0) begin
                    n_errors++;
                    $display("FAIL lone_word%0d got d=%h s=%b", nout, out_data, sel);
                end
                nout++;
            end
            if (fa) begin
                na++;
                if (na < 10) a_data = words[na]; else a_valid = 1'b0;
            end
        end
        n_checks++;
        if (nout !== 10) begin
            n_errors++;
            $display("FAIL lone_count got %0d exp 10", nout);
        end
    endtask

    task automatic test_random();
        logic [8:0] exp_q [$];
        logic [8:0] head;
        logic fa, fb, gen;
        do_reset();
        gen = 1'b1;
        for (int it = 0; it < 460; it++) begin
            if (it == 400) gen = 1'b0;
            @(negedge clk);
            n_checks++;
            if ((a_ready && b_ready) || a_ready !== (state_o == 2'd1 && (!out_valid || out_ready)) ||
                b_ready !== (state_o == 2'd2 && (!out_valid || out_ready))) begin
                n_errors++;
                $display("FAIL rand_ready it%0d got ar=%b br=%b st=%0d", it, a_ready, b_ready, state_o);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand_spurious got d=%h s=%b exp no word", out_data, sel);
                end else begin
                    head = exp_q.pop_front();
                    if ({sel, out_data} !== head) begin
                        n_errors++;
                        $display("FAIL rand_word got s=%b d=%h exp s=%b d=%h", sel, out_data, head[8], head[7:0]);
                    end
                end
            end
            fa = a_valid && a_ready; fb = b_valid && b_ready;
            if (fa) exp_q.push_back({1'b0, a_data});
            if (fb) exp_q.push_back({1'b1, b_data});
            @(posedge clk); #1;
            if (fa) a_valid = 1'b0;
            if (fb) b_valid = 1'b0;
            if (gen && !a_valid && $urandom_range(0, 3) != 0) begin a_valid = 1'b1; a_data = 8'($urandom); end
            if (gen && !b_valid && $urandom_range(0, 3) != 0) begin b_valid = 1'b1; b_data = 8'($urandom); end
            out_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        n_checks++;
        if (exp_q.size() != 0 || a_valid || b_valid) begin
            n_errors++;
            $display("FAIL rand_drain got pending=%0d av=%b bv=%b exp 0 0 0", exp_q.size(), a_valid, b_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_early_drop();
        test_lone_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
